wire_reg_signals_unit: RTL and testbench
========================================

// Module: wire_reg_signals_unit
// PURPOSE
//  Teaching/demo block contrasting wire (combinational) and reg (registered) signals.
//  Computes q = (i_a | i_b) & i_b, both combinationally and registered.
//  Adds edge pulses and a rising-edge counter on the registered result.
//  Leaf block; inputs come from a testbench or GPIO, outputs go to monitors/LEDs.
// PARAMETERS
//  CNT_W  8  width of the saturating rising-edge counter o_cnt (>=1)
// PORTS
//  i_clk    in   1      single clock, all flops rise-edge triggered
//  i_rst_n  in   1      reset, asynchronous assert, active-low
//  i_a      in   1      operand A
//  i_b      in   1      operand B
//  i_clr    in   1      synchronous clear of o_cnt
//  o_q      out  1      combinational (i_a | i_b) & i_b (wire)
//  o_q_r    out  1      registered q (reg)
//  o_rise   out  1      1-cycle pulse, o_q_r went 0->1
//  o_fall   out  1      1-cycle pulse, o_q_r went 1->0
//  o_cnt    out  CNT_W  count of o_rise pulses, saturating
//  Declaration order: i_a, i_b, o_q first (positional-instantiation compatible), then the rest.
// BEHAVIOUR
//  - o_q: pure combinational, zero latency, no clock/reset dependence; must equal (i_a|i_b)&i_b
//    (logically == i_b); implement the expression literally, not the simplification.
//  - Truth table (i_a,i_b -> o_q): 00->0, 10->0, 01->1, 11->1.
//  - Reset (i_rst_n=0, async): o_q_r=0, o_rise=0, o_fall=0, o_cnt=0, internal prev-state=0.
//    Reset mid-operation clears immediately; o_q unaffected.
//  - o_q_r <= q each rising i_clk: 1-cycle latency from inputs.
//  - o_rise/o_fall registered: asserted the cycle after o_q_r changes, for exactly 1 cycle.
//    No edge pulse generated by the reset release itself (prev-state resets to 0, o_q_r to 0).
//  - o_cnt: +1 per o_rise; holds at 2^CNT_W-1 (no wrap).
//  - i_clr=1: o_cnt<=0 next edge; clear wins over a simultaneous increment.
//  - X on inputs: not filtered; propagates.
// CONFIGURATION
//  WIRE_REG_SIGNALS_SYNC_EN defined: i_a, i_b pass a 2-flop synchronizer (reset 0) before
//    the registered path; o_q_r latency becomes 3 cycles; o_q stays combinational from raw pins.
//  Undefined: no synchronizer; o_q_r latency 1 cycle.
// STRUCTURE
//  Package wire_reg_signals_pkg: CNT_W_DEF=8, typedef logic [CNT_W_DEF-1:0] wrs_cnt_t,
//    constant Q_RESET=1'b0.
//  Sub-module wrs_edge_det: 1-bit edge detector (i_clk, i_rst_n, i_d -> o_rise, o_fall).
//  Top: combinational expr, optional synchronizer, q register, edge_det instance, counter.
// TESTING
//  1 Async reset: drive i_rst_n=0 between clock edges -> all reg outputs 0 immediately.
//  2 Sequence 00,10,01,11 held 10 ns each -> o_q 0,0,1,1 within same step; o_q_r 1 clk later.
//  3 Toggle i_b 0->1->0 (i_a=0) -> o_rise once, then o_fall once, each 1 cycle; o_cnt=1.
//  4 Generate 300 rises, CNT_W=8 -> o_cnt saturates at 255.
//  5 i_clr=1 concurrent with rise -> o_cnt=0 next cycle.
//  6 With WIRE_REG_SIGNALS_SYNC_EN: i_b 0->1 -> o_q_r high after 3 clks; o_q immediate.

Source files
------------

// File: rtl/wire_reg_signals_pkg.sv
// Shared constants and types for the wire/reg demonstration unit.
// Optional build macro used by the top: WIRE_REG_SIGNALS_SYNC_EN.
package wire_reg_signals_pkg;

  localparam int CNT_W_DEF = 8;

  typedef logic [CNT_W_DEF-1:0] wrs_cnt_t;

  // Value every registered observation bit takes while in reset.
  localparam logic Q_RESET = 1'b0;

endpackage

// File: rtl/wrs_edge_det.sv
// One-bit registered edge detector: o_rise / o_fall pulse for exactly one cycle,
// one cycle after i_d changes. History starts at Q_RESET so reset release is silent.
module wrs_edge_det
  import wire_reg_signals_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev   <= Q_RESET;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      prev   <= i_d;
      o_rise <= i_d & ~prev;
      o_fall <= ~i_d & prev;
    end
  end

endmodule

// File: rtl/wire_reg_signals_unit.sv
// Contrasts a combinational result (o_q) with its registered copy (o_q_r), plus edge
// pulses and a saturating rise counter. Define WIRE_REG_SIGNALS_SYNC_EN to add a
// 2-flop input synchronizer ahead of the registered path (o_q_r latency 3 instead of 1).
module wire_reg_signals_unit
  import wire_reg_signals_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_a,
  input  logic             i_b,
  output logic             o_q,
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  output logic             o_q_r,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_cnt
);

  logic a_src;
  logic b_src;
  logic q_src;

  // Written out literally on purpose: the demo shows the expression, not its reduction to i_b.
  assign o_q = (i_a | i_b) & i_b;

`ifdef WIRE_REG_SIGNALS_SYNC_EN
  logic [1:0] raw_in;
  logic [1:0] sync_out;

  assign raw_in = {i_b, i_a};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic stage1;
    logic stage2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        stage1 <= 1'b0;
        stage2 <= 1'b0;
      end else begin
        stage1 <= raw_in[gi];
        stage2 <= stage1;
      end
    end

    assign sync_out[gi] = stage2;
  end

  assign a_src = sync_out[0];
  assign b_src = sync_out[1];
`else
  assign a_src = i_a;
  assign b_src = i_b;
`endif

  assign q_src = (a_src | b_src) & b_src;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q_r <= Q_RESET;
    end else begin
      o_q_r <= q_src;
    end
  end

  wrs_edge_det u_edge_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (o_q_r),
    .o_rise  (o_rise),
    .o_fall  (o_fall)
  );

  // Clear has priority; the counter parks at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (o_rise && (o_cnt != {CNT_W{1'b1}})) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wire_reg_signals_unit.sv
// Randomized and directed stimulus for wire_reg_signals_unit against a cycle-history
// reference model (delay queue for o_q_r, edge history, saturating count).
module tb_wire_reg_signals_unit;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef WIRE_REG_SIGNALS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             clr = 1'b0;
  logic             q;
  logic             q_r;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: q values waiting to appear on o_q_r, and recent o_q_r history.
  bit qs[$];
  bit qr_p1, qr_p2, rise_p;
  int m_cnt;

  always #5 clk = ~clk;

  wire_reg_signals_unit #(.CNT_W(CNT_W)) dut (
    .i_a     (a),
    .i_b     (b),
    .o_q     (q),
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (clr),
    .o_q_r   (q_r),
    .o_rise  (rise),
    .o_fall  (fall),
    .o_cnt   (cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    qs.delete();
    for (int i = 0; i < LAT - 1; i++) qs.push_back(1'b0);
    qr_p1  = 1'b0;
    qr_p2  = 1'b0;
    rise_p = 1'b0;
    m_cnt  = 0;
  endtask

  // Assert reset mid-cycle, check outputs clear immediately, release well before the next negedge.
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_q_r", {31'b0, q_r}, 0);
    check_eq("rst_rise", {31'b0, rise}, 0);
    check_eq("rst_fall", {31'b0, fall}, 0);
    check_eq("rst_cnt", 32'(cnt), 0);
    check_eq("rst_q", {31'b0, q}, {31'b0, (a | b) & b});
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    $display("reset applied at %0t", $time);
  endtask

  task automatic do_cycle(input logic a_in, input logic b_in, input logic clr_in);
    bit exp_q, exp_qr, exp_rise, exp_fall;
    @(negedge clk);
    a   = a_in;
    b   = b_in;
    clr = clr_in;
    exp_q = (a_in | b_in) & b_in;
    #1 check_eq("o_q", {31'b0, q}, {31'b0, exp_q});
    @(posedge clk);
    cyc++;
    qs.push_back(exp_q);
    exp_qr   = qs.pop_front();
    exp_rise = qr_p1 & ~qr_p2;
    exp_fall = ~qr_p1 & qr_p2;
    if (clr_in)      m_cnt = 0;
    else if (rise_p) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    qr_p2  = qr_p1;
    qr_p1  = exp_qr;
    rise_p = exp_rise;
    #1;
    check_eq("o_q_r", {31'b0, q_r}, {31'b0, exp_qr});
    check_eq("o_rise", {31'b0, rise}, {31'b0, exp_rise});
    check_eq("o_fall", {31'b0, fall}, {31'b0, exp_fall});
    check_eq("o_cnt", 32'(cnt), m_cnt);
    $display("cyc %0d a=%b b=%b clr=%b q=%b q_r=%b rise=%b fall=%b cnt=%0d",
             cyc, a_in, b_in, clr_in, q, q_r, rise, fall, cnt);
  endtask

  initial begin
    int first_hi;
    model_reset();
    #2;
    check_eq("init_q_r", {31'b0, q_r}, 0);
    check_eq("init_cnt", 32'(cnt), 0);
    check_eq("init_rise", {31'b0, rise}, 0);
    rst_n = 1'b1;

    // Truth-table walk.
    do_reset();
    do_cycle(0, 0, 0);
    do_cycle(1, 0, 0);
    do_cycle(0, 1, 0);
    do_cycle(1, 1, 0);
    repeat (LAT + 2) do_cycle(0, 0, 0);

    // Single pulse on i_b: one rise, one fall, count of one.
    do_reset();
    do_cycle(0, 0, 0);
    do_cycle(0, 1, 0);
    repeat (LAT + 4) do_cycle(0, 0, 0);
    check_eq("pulse_cnt", 32'(cnt), 1);

    // Latency from i_b going high to o_q_r following.
    do_reset();
    first_hi = 0;
    for (int i = 1; i <= 6; i++) begin
      do_cycle(0, 1, 0);
      if (first_hi == 0 && q_r === 1'b1) first_hi = i;
    end
    check_eq("latency", first_hi, LAT);

    // 300 rises saturate the counter.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1, 0);
      do_cycle(1'($urandom_range(0, 1)), 0, 0);
    end
    repeat (LAT + 3) do_cycle(0, 0, 0);
    check_eq("sat_cnt", 32'(cnt), CNT_MAX);

    // Clear on the same edge that would count a rise.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 1, 0);
      do_cycle(0, 0, 0);
    end
    do_cycle(0, 1, 0);
    for (int i = 0; i < 10 && !rise_p; i++) do_cycle(0, 1, 0);
    check_eq("clr_setup_rise", {31'b0, rise}, 1);
    do_cycle(0, 1, 1);
    check_eq("clr_cnt", 32'(cnt), 0);

    // Random traffic, with a reset landing mid-stream.
    do_reset();
    for (int i = 0; i < 500; i++)
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    do_reset();
    for (int i = 0; i < 300; i++)
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
